// File: rtl/qtable_pkg.sv
// Shared constants, FSM encoding and packet-type codes for the neighbour Q-table reader and updater.
package qtable_pkg;

  localparam int WORD_WIDTH    = 16;
  localparam int MAX_NEIGHBORS = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam word_t E_MIN = 16'h0800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } qtable_state_e;

  // Packet types the update block uses when it writes into the neighbour banks
  typedef enum logic [1:0] {
    PKT_DATA         = 2'd0,
    PKT_ACK          = 2'd1,
    PKT_HELLO        = 2'd2,
    PKT_ROUTE_UPDATE = 2'd3
  } qtable_pkt_e;

endpackage

// File: rtl/qtable_best_hop_select_if.sv
// Start/bank/result bundle between the best-hop selector (slave) and its user (master).
interface qtable_best_hop_select_if;
  import qtable_pkg::*;

  logic  en;
  word_t neighborCount;
  logic  rd_en;
  word_t rd_index;
  word_t mSourceID;
  word_t mSourceHops;
  word_t mEnergyLeft;
  word_t mQValue;
  word_t bestID;
  word_t bestHops;
  word_t bestQValue;
  logic  best_valid;
  logic  busy;
  logic  done;

  modport slave (
    input  en, neighborCount, mSourceID, mSourceHops, mEnergyLeft, mQValue,
    output rd_en, rd_index, bestID, bestHops, bestQValue, best_valid, busy, done
  );

  modport master (
    output en, neighborCount, mSourceID, mSourceHops, mEnergyLeft, mQValue,
    input  rd_en, rd_index, bestID, bestHops, bestQValue, best_valid, busy, done
  );

endinterface

// File: rtl/qtable_entry_cmp.sv
// Combinational candidate-vs-best compare for the Q-table scan.
// Build option QTABLE_ENERGY_FILTER_EN makes neighbours below E_MIN energy ineligible.
module qtable_entry_cmp
  import qtable_pkg::*;
(
  input  word_t candQ_i,
  input  word_t candHops_i,
  input  word_t candEnergy_i,
  input  word_t bestQ_i,
  input  word_t bestHops_i,
  input  logic  bestValid_i,
  output logic  replace_o
);

  logic better;
  logic eligible;

  // Equal Q and equal hops never replace, so the earliest scanned entry keeps the tie
  always_comb begin
    better = !bestValid_i
             || (candQ_i > bestQ_i)
             || ((candQ_i == bestQ_i) && (candHops_i < bestHops_i));
`ifdef QTABLE_ENERGY_FILTER_EN
    eligible = (candEnergy_i >= E_MIN);
`else
    eligible = 1'b1;
`endif
    replace_o = eligible && better;
  end

`ifndef QTABLE_ENERGY_FILTER_EN
  logic unusedEnergy;
  assign unusedEnergy = ^candEnergy_i;
`endif

endmodule

// File: rtl/qtable_best_hop_select.sv
// Neighbour Q-table reader: scans bank entries 0..N-1 and keeps the highest-Q next hop.
// Build option QTABLE_ENERGY_FILTER_EN (inside qtable_entry_cmp) filters low-energy neighbours.
module qtable_best_hop_select
  import qtable_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  qtable_best_hop_select_if.slave bus
);

  localparam word_t MaxN = word_t'(MAX_NEIGHBORS);

  qtable_state_e state_q, state_d;
  logic  start_q, start_d;
  word_t n_q, n_d;
  word_t idx_q, idx_d;
  logic  vld_q, vld_d;
  word_t bestId_q, bestId_d;
  word_t bestHops_q, bestHops_d;
  word_t bestQ_q, bestQ_d;
  logic  bestValid_q, bestValid_d;
  logic  accept;
  logic  replace;

  assign accept = (state_q == IDLE) && !start_q && bus.en;

  qtable_entry_cmp u_cmp (
    .candQ_i      (bus.mQValue),
    .candHops_i   (bus.mSourceHops),
    .candEnergy_i (bus.mEnergyLeft),
    .bestQ_i      (bestQ_q),
    .bestHops_i   (bestHops_q),
    .bestValid_i  (bestValid_q),
    .replace_o    (replace)
  );

  // start_q spends one launch cycle in IDLE after acceptance, so index 0 goes out one cycle later
  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    n_d         = n_q;
    idx_d       = idx_q;
    vld_d       = (state_q == SCAN);
    bestId_d    = bestId_q;
    bestHops_d  = bestHops_q;
    bestQ_d     = bestQ_q;
    bestValid_d = bestValid_q;

    if (accept) begin
      start_d     = 1'b1;
      n_d         = (bus.neighborCount > MaxN) ? MaxN : bus.neighborCount;
      bestId_d    = '0;
      bestHops_d  = '0;
      bestQ_d     = '0;
      bestValid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_q) begin
          idx_d   = '0;
          state_d = (n_q == '0) ? FIN : SCAN;
        end
      end
      SCAN: begin
        idx_d = idx_q + 16'd1;
        if (idx_q == n_q - 16'd1) state_d = DRAIN;
      end
      DRAIN:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (vld_q && replace) begin
      bestId_d    = bus.mSourceID;
      bestHops_d  = bus.mSourceHops;
      bestQ_d     = bus.mQValue;
      bestValid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      n_q         <= '0;
      idx_q       <= '0;
      vld_q       <= 1'b0;
      bestId_q    <= '0;
      bestHops_q  <= '0;
      bestQ_q     <= '0;
      bestValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      vld_q       <= vld_d;
      bestId_q    <= bestId_d;
      bestHops_q  <= bestHops_d;
      bestQ_q     <= bestQ_d;
      bestValid_q <= bestValid_d;
    end
  end

  assign bus.rd_en      = (state_q == SCAN);
  assign bus.rd_index   = (state_q == SCAN) ? idx_q : '0;
  assign bus.done       = (state_q == FIN);
  assign bus.busy       = start_q || (state_q != IDLE);
  assign bus.bestID     = bestId_q;
  assign bus.bestHops   = bestHops_q;
  assign bus.bestQValue = bestQ_q;
  assign bus.best_valid = bestValid_q;

endmodule
